debug_recolector: RTL

Debug-mode collector that reads out the architectural state after the pipeline halts. On a start pulse it walks the register file through its combinational debug read port, together with the halted PC and the cycle count. It serializes every 32-bit word MSB-first as bytes into the UART transmitter's byte handshake. It sits between the ID stage's register file debug port and the debug unit's UART TX, and is the reading end of the register-file debug interface.

---
 rtl/debug_recolector_if.sv | 28 ++
 rtl/debug_recolector.sv | 130 +++++++++++++
 2 files changed

// File: rtl/debug_recolector_if.sv
// Handshake bundle between the debug collector, the register-file debug port
// and the UART TX byte interface.
interface debug_recolector_if #(
  parameter int len_data = 32,
  parameter int num_bits = 5,
  parameter int len_byte = 8
);
  logic                start;
  logic [len_data-1:0] in_pc;
  logic [len_data-1:0] in_cycle_count;
  logic [len_data-1:0] in_reg_data;
  logic                in_tx_done;
  logic [num_bits-1:0] out_reg_addr;
  logic [len_byte-1:0] out_tx_data;
  logic                out_tx_start;
  logic                out_busy;
  logic                out_done;

  modport slave (
    input  start, in_pc, in_cycle_count, in_reg_data, in_tx_done,
    output out_reg_addr, out_tx_data, out_tx_start, out_busy, out_done
  );

  modport master (
    output start, in_pc, in_cycle_count, in_reg_data, in_tx_done,
    input  out_reg_addr, out_tx_data, out_tx_start, out_busy, out_done
  );
endinterface

// File: rtl/debug_recolector.sv
// Post-halt state dump: PC, cycle count, then every register, each word sent
// MSB-first as bytes over the UART TX byte handshake.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture selected word (PC / cycle count / register) into shift reg
// SEND  | one-cycle out_tx_start with the top byte of the shift reg
// WAIT  | hold byte until UART reports done
// NEXT  | advance to the next word or finish
// DONE  | one-cycle out_done pulse
module debug_recolector #(
  parameter int len_data = 32,
  parameter int num_bits = 5,
  parameter int num_regs = 32,
  parameter int len_byte = 8
) (
  input  logic              clk,
  input  logic              reset,
  debug_recolector_if.slave dbg
);

  localparam int WIDX_W = $clog2(num_regs + 2);
  localparam int BYTES  = len_data / len_byte;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(num_regs + 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic [2:0]          state_q,    state_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [len_data-1:0] shift_q,    shift_d;
  logic [num_bits-1:0] reg_addr_q, reg_addr_d;
  logic [len_byte-1:0] tx_data_q,  tx_data_d;

  logic [len_data-1:0] word_sel;
  logic [WIDX_W-1:0]   idx_inc;

  always_comb begin
    word_sel = dbg.in_reg_data;
    if (word_idx_q == '0) begin
      word_sel = dbg.in_pc;
    end else if (word_idx_q == WIDX_W'(1)) begin
      word_sel = dbg.in_cycle_count;
    end
  end

  assign idx_inc = word_idx_q + WIDX_W'(1);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (dbg.start) begin
          state_d    = ST_LOAD;
          word_idx_d = '0;
          reg_addr_d = '0;
        end
      end
      ST_LOAD: begin
        shift_d    = word_sel;
        byte_idx_d = '0;
        tx_data_d  = word_sel[len_data-1 -: len_byte];
        state_d    = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (dbg.in_tx_done) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = ST_NEXT;
          end else begin
            // tx_data takes the byte that becomes the new top of the shift reg
            shift_d    = shift_q << len_byte;
            tx_data_d  = shift_q[len_data-len_byte-1 -: len_byte];
            byte_idx_d = byte_idx_q + BIDX_W'(1);
            state_d    = ST_SEND;
          end
        end
      end
      ST_NEXT: begin
        if (word_idx_q == LAST_WORD) begin
          state_d = ST_DONE;
        end else begin
          word_idx_d = idx_inc;
          reg_addr_d = (idx_inc >= WIDX_W'(2)) ? num_bits'(idx_inc - WIDX_W'(2)) : '0;
          state_d    = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign dbg.out_reg_addr = reg_addr_q;
  assign dbg.out_tx_data  = tx_data_q;
  assign dbg.out_tx_start = (state_q == ST_SEND);
  assign dbg.out_busy     = (state_q != ST_IDLE);
  assign dbg.out_done     = (state_q == ST_DONE);

endmodule
